// File: rtl/alu_types.sv
// ============================================================================
// Module      : alu_types (package)
// Description : Shared types for the ALU and the two-requester ALU arbiter.
//               alu_control_t selects the ALU operation; alu_arb_state_t is
//               the arbiter FSM state. Also provides the round-robin grant
//               helper used by the arbiter.
// Contents    : c_alu_width      - supported datapath width
//               alu_control_t    - 3-bit ALU opcode
//               alu_arb_state_t  - 2-bit arbiter state
//               alu_arb_grant()  - one-hot grant from valids and pointer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_types;

    localparam int unsigned c_alu_width = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_control_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } alu_arb_state_t;

    // Returns {grant1, grant0}. i_prio names the requester that wins when
    // both are valid; a lone valid requester always wins.
    function automatic logic [1:0] alu_arb_grant(
        input logic i_v0,
        input logic i_v1,
        input logic i_prio
    );
        logic [1:0] w_g;
        w_g[0] = i_v0 & (~i_v1 | ~i_prio);
        w_g[1] = i_v1 & (~i_v0 |  i_prio);
        return w_g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Purely combinational N-bit ALU with wrapping arithmetic.
// Ports       : i_a, i_b      - operands
//               i_control     - operation select (alu_control_t)
//               o_result      - N-bit result
//               o_overflow    - signed overflow (ADD/SUB only, else 0)
//               o_zero        - result is all zeros
//               o_equal       - operands are equal
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
    input  alu_control_t  i_control,
    output logic [N-1:0]  o_result,
    output logic          o_overflow,
    output logic          o_zero,
    output logic          o_equal
);

    localparam int unsigned c_shw = $clog2(N);

    // Sign-extended by one bit: the top two bits differ exactly when the
    // N-bit signed result overflowed, and the extra bit of the difference is
    // the true signed less-than.
    logic [N:0]     w_sum;
    logic [N:0]     w_diff;
    logic [N-1:0]   w_result;
    logic           w_overflow;

    assign w_sum  = {i_a[N-1], i_a} + {i_b[N-1], i_b};
    assign w_diff = {i_a[N-1], i_a} - {i_b[N-1], i_b};

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (i_control)
            ALU_ADD: begin
                w_result   = w_sum[N-1:0];
                w_overflow = w_sum[N] ^ w_sum[N-1];
            end
            ALU_SUB: begin
                w_result   = w_diff[N-1:0];
                w_overflow = w_diff[N] ^ w_diff[N-1];
            end
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_XOR: w_result = i_a ^ i_b;
            ALU_SLL: w_result = i_a << i_b[c_shw-1:0];
            ALU_SRL: w_result = i_a >> i_b[c_shw-1:0];
            ALU_SLT: w_result = {{(N-1){1'b0}}, w_diff[N]};
            default: w_result = '0;
        endcase
    end

    assign o_result   = w_result;
    assign o_overflow = w_overflow;
    assign o_zero     = (w_result == '0);
    assign o_equal    = (i_a == i_b);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Time-shares a single ALU between two requesters. One
//               operation is in flight at a time: IDLE (grant/accept),
//               EXEC (ALU fed from operand registers, result captured),
//               RESP (result held until the consumer takes it).
//               Contention is resolved round-robin.
// Ports       : clk                      - clock, rising edge
//               rst                      - synchronous reset, active low
//               reqX_valid / reqX_ready  - requester X handshake (X = 0, 1)
//               reqX_a, reqX_b           - requester X operands
//               reqX_control             - requester X operation
//               out_valid / out_ready    - result handshake
//               out_id                   - requester that issued the result
//               out_result               - captured ALU result
//               out_overflow/zero/equal  - captured ALU flags
//               busy                     - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [N-1:0]  req0_b,
    input  logic [N-1:0]  req1_a,
    input  logic [N-1:0]  req1_b,
    input  alu_control_t  req0_control,
    input  alu_control_t  req1_control,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_id,
    output logic [N-1:0]  out_result,
    output logic          out_overflow,
    output logic          out_zero,
    output logic          out_equal,
    output logic          busy
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    alu_arb_state_t r_state;
    alu_arb_state_t w_state_next;

    // Requester that wins when both are valid; 0 out of reset.
    logic           r_prio;

    logic [N-1:0]   r_op_a;
    logic [N-1:0]   r_op_b;
    alu_control_t   r_op_ctrl;
    logic           r_op_id;

    logic [N-1:0]   r_out_result;
    logic           r_out_overflow;
    logic           r_out_zero;
    logic           r_out_equal;
    logic           r_out_id;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]     w_grant;
    logic           w_ready0;
    logic           w_ready1;
    logic           w_accept;
    logic           w_busy;
    logic           w_out_valid;

    logic [N-1:0]   w_alu_result;
    logic           w_alu_overflow;
    logic           w_alu_zero;
    logic           w_alu_equal;

    assign w_grant  = alu_arb_grant(req0_valid, req1_valid, r_prio);
    assign w_accept = w_ready0 | w_ready1;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: if (w_accept)  w_state_next = ARB_EXEC;
            ARB_EXEC:                w_state_next = ARB_RESP;
            ARB_RESP: if (out_ready) w_state_next = ARB_IDLE;
            default:                 w_state_next = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // Readys are only offered from IDLE and are masked while reset is
    // asserted so nothing can be accepted on a reset edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_busy      = 1'b1;
        w_out_valid = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_busy = 1'b0;
                if (rst) begin
                    w_ready0 = w_grant[0];
                    w_ready1 = w_grant[1];
                end
            end
            ARB_EXEC: w_busy = 1'b1;
            ARB_RESP: w_out_valid = 1'b1;
            default:  w_busy = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, result capture, round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prio         <= 1'b0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_op_ctrl      <= ALU_ADD;
            r_op_id        <= 1'b0;
            r_out_result   <= '0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b0;
            r_out_equal    <= 1'b0;
            r_out_id       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a    <= w_ready1 ? req1_a       : req0_a;
                r_op_b    <= w_ready1 ? req1_b       : req0_b;
                r_op_ctrl <= w_ready1 ? req1_control : req0_control;
                r_op_id   <= w_ready1;
            end
            if (r_state == ARB_EXEC) begin
                r_out_result   <= w_alu_result;
                r_out_overflow <= w_alu_overflow;
                r_out_zero     <= w_alu_zero;
                r_out_equal    <= w_alu_equal;
                r_out_id       <= r_op_id;
            end
            // Favour the other requester once this result is consumed.
            if ((r_state == ARB_RESP) && out_ready) begin
                r_prio <= ~r_out_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // The single shared ALU, fed only from the operand registers
    // ------------------------------------------------------------------
    alu #(
        .N (N)
    ) u_alu (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .i_control  (r_op_ctrl),
        .o_result   (w_alu_result),
        .o_overflow (w_alu_overflow),
        .o_zero     (w_alu_zero),
        .o_equal    (w_alu_equal)
    );

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign req0_ready   = w_ready0;
    assign req1_ready   = w_ready1;
    assign busy         = w_busy;
    assign out_valid    = w_out_valid;
    assign out_id       = r_out_id;
    assign out_result   = r_out_result;
    assign out_overflow = r_out_overflow;
    assign out_zero     = r_out_zero;
    assign out_equal    = r_out_equal;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Expected results are
//               computed by a reference ALU model and queued at accept time,
//               then popped and compared when the arbiter presents a result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_types::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    alu_control_t  req0_control, req1_control;
    logic          out_valid, out_ready, out_id;
    logic [31:0]   out_result;
    logic          out_overflow, out_zero, out_equal, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.N(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req0_control (req0_control),
        .req1_control (req1_control),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_equal    (out_equal),
        .busy         (busy)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        ovf;
        logic        zero;
        logic        equal;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic id, input alu_control_t c,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] r;
        logic        o;
        o = 1'b0;
        case (c)
            ALU_ADD: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        e.id     = id;
        e.result = r;
        e.ovf    = o;
        e.zero   = (r == 32'd0);
        e.equal  = (a == b);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive0(input logic v, input alu_control_t c, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_control = c; req0_a = a; req0_b = b;
    endtask

    task automatic drive1(input logic v, input alu_control_t c, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_control = c; req1_a = a; req1_b = b;
    endtask

    task automatic expect_rdy(input string tag, input logic e0, input logic e1);
        chk({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, e0});
        chk({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, e1});
    endtask

    task automatic push(input logic id);
        if (id) sb.push_back(model(1'b1, req1_control, req1_a, req1_b));
        else    sb.push_back(model(1'b0, req0_control, req0_a, req0_b));
    endtask

    task automatic expect_out(input string tag, input exp_t e);
        chk({tag, "_valid"},  {31'd0, out_valid},    32'd1);
        chk({tag, "_id"},     {31'd0, out_id},       {31'd0, e.id});
        chk({tag, "_result"}, out_result,            e.result);
        chk({tag, "_ovf"},    {31'd0, out_overflow}, {31'd0, e.ovf});
        chk({tag, "_zero"},   {31'd0, out_zero},     {31'd0, e.zero});
        chk({tag, "_equal"},  {31'd0, out_equal},    {31'd0, e.equal});
    endtask

    task automatic check_out(input string tag);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty-scoreboard expected=queued-result", tag);
        end else begin
            held = sb.pop_front();
            expect_out(tag, held);
        end
    endtask

    task automatic expect_cleared(input string tag);
        chk({tag, "_valid"},  {31'd0, out_valid},    32'd0);
        chk({tag, "_busy"},   {31'd0, busy},         32'd0);
        chk({tag, "_id"},     {31'd0, out_id},       32'd0);
        chk({tag, "_result"}, out_result,            32'd0);
        chk({tag, "_flags"},  {29'd0, out_overflow, out_zero, out_equal}, 32'd0);
    endtask

    initial begin
        // ---------------- reset with both requesters valid ----------------
        rst = 1'b0;
        out_ready = 1'b0;
        drive0(1'b1, ALU_SUB, 32'd9, 32'd9);
        drive1(1'b1, ALU_XOR, 32'hF0F0_0000, 32'h0F0F_0000);
        tick();
        tick();
        expect_rdy("reset", 1'b0, 1'b0);
        expect_cleared("reset");

        // ---------------- contention: ids alternate 0,1,0,1 ----------------
        out_ready = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            expect_rdy($sformatf("cont%0d_grant", i), (i % 2) == 0, (i % 2) == 1);
            push(logic'(i % 2));
            tick();
            chk($sformatf("cont%0d_exec_busy", i), {31'd0, busy}, 32'd1);
            chk($sformatf("cont%0d_exec_valid", i), {31'd0, out_valid}, 32'd0);
            expect_rdy($sformatf("cont%0d_exec", i), 1'b0, 1'b0);
            tick();
            check_out($sformatf("cont%0d", i));
            expect_rdy($sformatf("cont%0d_resp", i), 1'b0, 1'b0);
            tick();
            chk($sformatf("cont%0d_idle_busy", i), {31'd0, busy}, 32'd0);
        end
        drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
        drive1(1'b0, ALU_ADD, 32'd0, 32'd0);

        // ---------------- single request: 5 + 7 ----------------
        drive0(1'b1, ALU_ADD, 32'd5, 32'd7);
        settle();
        expect_rdy("single", 1'b1, 1'b0);
        push(1'b0);
        tick();
        chk("single_lat1_valid", {31'd0, out_valid}, 32'd0);
        drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();
        check_out("single");
        tick();
        chk("single_idle_busy", {31'd0, busy}, 32'd0);
        chk("single_idle_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- backpressure with req1 waiting ----------------
        out_ready = 1'b0;
        drive0(1'b1, ALU_AND, 32'hDEAD_BEEF, 32'h0F0F_F0F0);
        settle();
        expect_rdy("bp", 1'b1, 1'b0);
        push(1'b0);
        tick();
        drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
        drive1(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        check_out("bp0");
        for (int i = 1; i < 5; i++) begin
            tick();
            expect_out($sformatf("bp%0d", i), held);
            expect_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        settle();
        expect_rdy("bp_release", 1'b0, 1'b0);
        tick();
        chk("bp_idle_busy", {31'd0, busy}, 32'd0);
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- overflow from req1 ----------------
        expect_rdy("ovf", 1'b0, 1'b1);
        push(1'b1);
        tick();
        drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();
        check_out("ovf");
        tick();

        // ---------------- req0 SLT, leaves pointer favouring req1 ----------------
        drive0(1'b1, ALU_SLT, 32'hFFFF_FFFD, 32'd2);
        settle();
        expect_rdy("slt", 1'b1, 1'b0);
        push(1'b0);
        tick();
        drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();
        check_out("slt");
        tick();

        // ---------------- reset during EXEC ----------------
        drive1(1'b1, ALU_OR, 32'h1234_0000, 32'h0000_5678);
        settle();
        expect_rdy("mid", 1'b0, 1'b1);
        tick();
        chk("mid_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        drive0(1'b1, ALU_SRL, 32'h8000_0000, 32'd4);
        drive1(1'b1, ALU_SLL, 32'd1, 32'd31);
        tick();
        expect_cleared("mid_rst");
        expect_rdy("mid_rst_low", 1'b0, 1'b0);
        tick();
        expect_cleared("mid_rst2");
        rst = 1'b1;
        settle();
        expect_rdy("post_rst", 1'b1, 1'b0);
        push(1'b0);
        tick();
        chk("post_rst_exec_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check_out("post_rst0");
        tick();
        expect_rdy("post_rst_rr", 1'b0, 1'b1);
        push(1'b1);
        tick();
        drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
        drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
        tick();
        check_out("post_rst1");
        tick();
        chk("end_busy", {31'd0, busy}, 32'd0);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
